// File: rtl/sm_arith_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_arith_pkg                                                     |
// | Purpose  : Shared sign-magnitude arithmetic definitions: op encoding and    |
// |            width-generic conversion helpers between sign-magnitude and      |
// |            two's complement (with saturation on the way back).              |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package sm_arith_pkg;

  // Operation encoding carried on in_op.
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Widest sign-magnitude word the helpers handle. Callers zero-extend their
  // W-bit words into this container and pass W alongside, which lets one
  // pair of functions serve every instantiated width (W must be < SM_WMAX).
  localparam int SM_WMAX = 64;

  typedef logic [SM_WMAX:0] sm_tc_t;   // two's complement container

  typedef struct packed {
    logic               sat;
    logic [SM_WMAX-1:0] sm;
  } sm_sat_t;

  // Sign-magnitude (width w, zero-extended) to two's complement.
  // -0 maps to 0 because the negation of a zero magnitude is zero.
  function automatic sm_tc_t sm_to_tc(input logic [SM_WMAX-1:0] sm, input int w);
    sm_tc_t one;
    sm_tc_t mask;
    sm_tc_t mag;
    logic   sgn;
    one  = sm_tc_t'(1);
    mask = (one << (w - 1)) - one;
    mag  = {1'b0, sm} & mask;
    sgn  = |({1'b0, sm} & (one << (w - 1)));
    return sgn ? (~mag + one) : mag;
  endfunction

  // Two's complement to sign-magnitude of width w, clamping the magnitude at
  // 2^(w-1)-1. A zero result is always positive, so -0 is never produced.
  function automatic sm_sat_t tc_to_sm_sat(input sm_tc_t z, input int w);
    sm_tc_t  one;
    sm_tc_t  mag_max;
    sm_tc_t  abs_z;
    sm_tc_t  sign_bit;
    sm_sat_t r;
    one      = sm_tc_t'(1);
    mag_max  = (one << (w - 1)) - one;
    sign_bit = one << (w - 1);
    abs_z    = z[SM_WMAX] ? (~z + one) : z;
    r.sat    = (abs_z > mag_max);
    if (r.sat) begin
      abs_z = mag_max;
    end
    r.sm = abs_z[SM_WMAX-1:0];
    if (z[SM_WMAX]) begin
      r.sm = r.sm | sign_bit[SM_WMAX-1:0];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_accum_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_accum_pipe_if                                                 |
// | Purpose  : Request/result handshake bundle for sm_accum_pipe.               |
// | Ports    : request  in_valid/in_ready/in_op/in_ch/in_x/in_y                 |
// |            result   out_valid/out_ready/out_sum/out_ch/out_sat              |
// |            modport master = requester/consumer, slave = the pipeline        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface sm_accum_pipe_if #(
  parameter int W  = 24,
  parameter int CH = 4
);
  localparam int CHW = $clog2(CH);

  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_op;
  logic [CHW-1:0] in_ch;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;

  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_sum;
  logic [CHW-1:0] out_ch;
  logic           out_sat;

  modport master (
    output in_valid, in_op, in_ch, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_sum, out_ch, out_sat
  );

  modport slave (
    input  in_valid, in_op, in_ch, in_x, in_y, out_ready,
    output in_ready, out_valid, out_sum, out_ch, out_sat
  );

endinterface
`default_nettype wire

// File: rtl/sm_sat_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_sat_core                                                      |
// | Purpose  : Combinational saturating sign-magnitude add/subtract.            |
// | Ports    : a_sm, b_sm  in  W   sign-magnitude operands                      |
// |            op_sub      in  1   1: a-b, 0: a+b                               |
// |            sum_sm      out W   saturated, canonical sign-magnitude result   |
// |            sat         out 1   result magnitude was clamped                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sm_sat_core
  import sm_arith_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [W-1:0] a_sm,
  input  logic [W-1:0] b_sm,
  input  logic         op_sub,
  output logic [W-1:0] sum_sm,
  output logic         sat
);

  logic [SM_WMAX-1:0] a_wide;
  logic [SM_WMAX-1:0] b_wide;
  sm_tc_t             a_conv;
  sm_tc_t             b_conv;
  logic [W:0]         a_tc;
  logic [W:0]         b_tc;
  logic [W:0]         z_tc;
  sm_tc_t             z_wide;
  sm_sat_t            res;
  logic               unused_hi;

  always_comb begin
    a_wide         = '0;
    a_wide[W-1:0]  = a_sm;
    b_wide         = '0;
    b_wide[W-1:0]  = b_sm;
    a_conv         = sm_to_tc(a_wide, W);
    b_conv         = sm_to_tc(b_wide, W);
    a_tc           = a_conv[W:0];
    b_tc           = b_conv[W:0];
    // |a|,|b| <= 2^(W-1)-1, so the sum/difference always fits in W+1 bits.
    z_tc           = op_sub ? (a_tc - b_tc) : (a_tc + b_tc);
    z_wide         = {{(SM_WMAX - W){z_tc[W]}}, z_tc};
    res            = tc_to_sm_sat(z_wide, W);
    sum_sm         = res.sm[W-1:0];
    sat            = res.sat;
  end

  // Container bits above the working width carry only sign extension/zeros.
  assign unused_hi = ^{a_conv[SM_WMAX:W+1], b_conv[SM_WMAX:W+1], res.sm[SM_WMAX-1:W]};

endmodule
`default_nettype wire

// File: rtl/sm_accum_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_accum_pipe                                                    |
// | Purpose  : Two-stage valid/ready pipeline around a saturating sign-         |
// |            magnitude core with CH running accumulators (ADD/SUB/ACC/LOAD).  |
// | Ports    : clk         in      clock, rising edge                           |
// |            rst         in      synchronous active-high reset                |
// |            bus         slave   request/result handshake bundle              |
// |            sat_sticky  out CH  per-channel sticky saturation flags          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sm_accum_pipe
  import sm_arith_pkg::*;
#(
  parameter int W  = 24,
  parameter int CH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sm_accum_pipe_if.slave       bus,
  output logic [CH-1:0]        sat_sticky
);

  localparam int CHW = $clog2(CH);

  // Stage 1: registered request
  logic           s1_valid_q, s1_valid_d;
  logic [1:0]     s1_op_q,    s1_op_d;
  logic [CHW-1:0] s1_ch_q,    s1_ch_d;
  logic [W-1:0]   s1_x_q,     s1_x_d;
  logic [W-1:0]   s1_y_q,     s1_y_d;

  // Stage 2: registered result
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_sum_q,   out_sum_d;
  logic [CHW-1:0] out_ch_q,    out_ch_d;
  logic           out_sat_q,   out_sat_d;

  // Per-channel state
  logic [W-1:0]   acc_q [CH];
  logic [W-1:0]   acc_d [CH];
  logic [CH-1:0]  sat_sticky_q, sat_sticky_d;

  logic           s2_load;
  logic           s1_load;
  logic           xfer;
  logic [W-1:0]   acc_rd;
  logic [W-1:0]   core_a;
  logic [W-1:0]   core_b;
  logic           core_sub;
  logic [W-1:0]   core_sum;
  logic           core_sat;

  assign s2_load = !out_valid_q || bus.out_ready;
  assign s1_load = !s1_valid_q || s2_load;
  assign xfer    = s1_valid_q && s2_load;

  // Operand selection. The accumulator is read at the same edge it is
  // written, so consecutive ACCs on one channel chain without forwarding.
  always_comb begin
    acc_rd = '0;
    for (int i = 0; i < CH; i++) begin
      if (s1_ch_q == CHW'(i)) begin
        acc_rd = acc_q[i];
      end
    end
    core_a   = s1_x_q;
    core_b   = s1_y_q;
    core_sub = 1'b0;
    case (s1_op_q)
      OP_SUB:  core_sub = 1'b1;
      OP_ACC: begin
        core_a = acc_rd;
        core_b = s1_x_q;
      end
      OP_LOAD: core_b = '0;   // X + 0 canonicalises -0 to +0
      default: ;
    endcase
  end

  sm_sat_core #(.W(W)) u_core (
    .a_sm   (core_a),
    .b_sm   (core_b),
    .op_sub (core_sub),
    .sum_sm (core_sum),
    .sat    (core_sat)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_ch_d    = s1_ch_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    if (s1_load) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_op_d = bus.in_op;
        s1_ch_d = bus.in_ch;
        s1_x_d  = bus.in_x;
        s1_y_d  = bus.in_y;
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;
    out_ch_d     = out_ch_q;
    out_sat_d    = out_sat_q;
    acc_d        = acc_q;
    sat_sticky_d = sat_sticky_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
    end
    if (xfer) begin
      out_sum_d = core_sum;
      out_ch_d  = s1_ch_q;
      out_sat_d = (s1_op_q == OP_LOAD) ? 1'b0 : core_sat;
      for (int i = 0; i < CH; i++) begin
        if (s1_ch_q == CHW'(i)) begin
          if ((s1_op_q == OP_ACC) || (s1_op_q == OP_LOAD)) begin
            acc_d[i] = core_sum;
          end
          // LOAD wins over a simultaneous set on the same channel.
          if (s1_op_q == OP_LOAD) begin
            sat_sticky_d[i] = 1'b0;
          end else if (core_sat) begin
            sat_sticky_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_ch_q      <= '0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_ch_q     <= '0;
      out_sat_q    <= 1'b0;
      sat_sticky_q <= '0;
      for (int i = 0; i < CH; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_ch_q      <= s1_ch_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_ch_q     <= out_ch_d;
      out_sat_q    <= out_sat_d;
      sat_sticky_q <= sat_sticky_d;
      for (int i = 0; i < CH; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_sat   = out_sat_q;
  assign sat_sticky    = sat_sticky_q;

endmodule
`default_nettype wire
